uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Sequencing controller for the UART transmit 8-bit shift register. Accepts a byte over a valid/ready handshake, pulses the shift register's load and shift strobes at baud-bit boundaries, and muxes the serial line between idle/stop level and the register's serial output. Sits between the host-side TX interface and the TX shift register; owns all baud timing and frame sequencing.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit period (100 MHz / 115200); legal range >= 2
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
tx_valid  input  1  host has a byte to send
tx_data  input  8  byte to send, sampled only on the accept cycle
tx_ready  output  1  controller can accept a byte (high only in IDLE)
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit
busy  output  1  frame in progress (state != IDLE)
sr_load  output  1  load strobe to shift register (register <= sr_data, serial out <= 0)
sr_shift  output  1  shift strobe to shift register (serial out <= bit0, register >> 1)
sr_data  output  8  parallel data to shift register
sr_y  input  1  serial output of shift register
tx  output  1  UART serial line

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, port named reset.
- Reset (async assert, any state incl. mid-frame): state=IDLE, baud_cnt=0, bit_cnt=0; outputs tx=1, tx_ready=1, busy=0, tx_done=0, sr_load=0, sr_shift=0, sr_data=0. No partial frame resumes after release.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, tx_ready=1. Accept when tx_valid&&tx_ready: sr_load=1 that cycle (combinational), sr_data=tx_data (combinational pass-through), next state START, baud_cnt=0.
- START: tx=sr_y (0 after load). Lasts CLKS_PER_BIT cycles. On last cycle (baud_cnt==CLKS_PER_BIT-1): sr_shift=1, bit_cnt=0, next DATA.
- DATA: tx=sr_y. Each bit lasts CLKS_PER_BIT cycles. On last cycle of bit k: if k<7 sr_shift=1, bit_cnt=k+1; if k==7 no shift, next STOP. Bits go out LSB first.
- STOP: tx=1 (forced, independent of sr_y) for STOP_BITS*CLKS_PER_BIT cycles; tx_done=1 on final cycle; next IDLE.
- baud_cnt width $clog2(CLKS_PER_BIT*STOP_BITS); resets to 0 at every state transition; wraps to 0 at each bit boundary inside DATA.
- sr_load and sr_shift never asserted in the same cycle; each is exactly one cycle wide.
- Timing: accept at cycle t -> tx low t+1..t+CLKS_PER_BIT; data bit k at t+1+(k+1)*CLKS_PER_BIT for CLKS_PER_BIT cycles; tx_done at t+(9+STOP_BITS)*CLKS_PER_BIT; tx_ready high again next cycle.
- tx_valid while busy: ignored, no load, tx_data not sampled. tx_valid asserted during tx_done cycle: not accepted until IDLE cycle (one idle cycle minimum between frames).
- tx_valid held high continuously: back-to-back frames, exactly one IDLE cycle (tx=1) between stop and next start.
- tx_data changing after accept has no effect on the frame in flight.

Test Plan:
- Reset: assert reset=0 mid-DATA with CLKS_PER_BIT=4 -> tx=1, tx_ready=1, busy=0, no sr_shift pulses after assertion; after release, send 0x00 frames correctly.
- Single frame 0xA5, CLKS_PER_BIT=4, STOP_BITS=1, accept at t -> tx=0 at t+1..t+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), tx=1 t+37..t+40, tx_done at t+40, tx_ready at t+41; exactly 1 sr_load and 8 sr_shift pulses.
- Back-to-back: tx_valid held high with 0x55 then 0xFF -> second sr_load at t+41, line decodes 0x55, 0xFF, one idle cycle between frames.
- Busy rejection: pulse tx_valid with 0x3C at t+10 during 0xA5 frame -> no sr_load, line still decodes only 0xA5.
- STOP_BITS=2, CLKS_PER_BIT=4, byte 0x80 -> tx high for 8 stop cycles, tx_done at t+44, tx_ready at t+45.
- tx_data changed to 0xFF the cycle after accepting 0x0F -> line decodes 0x0F.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencing controller.
// Owns baud timing and frame sequencing (start, 8 data bits LSB first, stop)
// and drives load/shift strobes to an external 8-bit TX shift register whose
// serial output is muxed onto the line during start and data bits.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       busy,
    output logic       sr_load,
    output logic       sr_shift,
    output logic [7:0] sr_data,
    input  logic       sr_y,
    output logic       tx
);

    localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
    localparam int CW        = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e        state_q;
    logic [CW-1:0] baud_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic          busy_q;

    logic accept;
    logic bit_end;
    logic stop_end;

    // Reset is folded into accept so no load strobe can escape while the
    // controller is held in reset with tx_valid high.
    assign accept   = reset && tx_valid && !busy_q;
    assign bit_end  = (baud_cnt_q == BIT_LAST);
    assign stop_end = (baud_cnt_q == STOP_LAST);

    // Frame sequencer: state, baud counter, bit index and registered busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= START;
                        baud_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q    <= DATA;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        state_q    <= IDLE;
                        baud_cnt_q <= '0;
                        busy_q     <= 1'b0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    baud_cnt_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Host handshake and status.
    assign tx_ready = !busy_q;
    assign busy     = busy_q;
    assign tx_done  = (state_q == STOP) && stop_end;

    // Shift register strobes: load on accept; shift at the end of the start
    // bit and of data bits 0..6 (bit 7 stays on the line until stop).
    assign sr_load  = accept;
    assign sr_data  = accept ? tx_data : 8'h00;
    assign sr_shift = bit_end && ((state_q == START) ||
                                  ((state_q == DATA) && (bit_cnt_q != 3'd7)));

    // Line mux: register output during start/data, idle/stop level otherwise.
    assign tx = ((state_q == START) || (state_q == DATA)) ? sr_y : 1'b1;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (1 and 2 stop bits, 4 clocks/bit),
// each with a behavioural shift register. Expected outputs come from a
// frame-offset model: given the accept cycle and byte, every output is a
// plain arithmetic function of the cycle offset into the frame.
module tb_uart_tx_ctrl;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_valid_a [2] = '{1'b0, 1'b0};
    logic [7:0] tx_data_a  [2] = '{8'h00, 8'h00};
    logic       tx_ready_a [2];
    logic       tx_done_a  [2];
    logic       busy_a     [2];
    logic       load_a     [2];
    logic       shift_a    [2];
    logic [7:0] sr_data_a  [2];
    logic       sr_y_a     [2];
    logic       tx_a       [2];
    logic [7:0] sr_reg     [2];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // model state per instance
    int         t_acc [2] = '{0, 0};
    bit         hv    [2] = '{1'b0, 1'b0};
    logic [7:0] fb    [2] = '{8'h00, 8'h00};

    // literal pins: written by the stimulus process, read by the compare process
    int   pin_cyc  [64];
    int   pin_inst [64];
    int   pin_sig  [64];
    logic pin_val  [64];
    int   npins = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid_a[0]), .tx_data(tx_data_a[0]),
        .tx_ready(tx_ready_a[0]), .tx_done(tx_done_a[0]), .busy(busy_a[0]),
        .sr_load(load_a[0]), .sr_shift(shift_a[0]), .sr_data(sr_data_a[0]),
        .sr_y(sr_y_a[0]), .tx(tx_a[0])
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid_a[1]), .tx_data(tx_data_a[1]),
        .tx_ready(tx_ready_a[1]), .tx_done(tx_done_a[1]), .busy(busy_a[1]),
        .sr_load(load_a[1]), .sr_shift(shift_a[1]), .sr_data(sr_data_a[1]),
        .sr_y(sr_y_a[1]), .tx(tx_a[1])
    );

    // behavioural TX shift registers driven by the DUT strobes
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                sr_reg[i] <= 8'h00;
                sr_y_a[i] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load_a[i]) begin
                    sr_reg[i] <= sr_data_a[i];
                    sr_y_a[i] <= 1'b0;
                end else if (shift_a[i]) begin
                    sr_y_a[i] <= sr_reg[i][0];
                    sr_reg[i] <= {1'b0, sr_reg[i][7:1]};
                end
            end
        end
    end

    function automatic string sig_name(input int s);
        case (s)
            0: return "tx";
            1: return "tx_ready";
            2: return "busy";
            3: return "sr_shift";
            4: return "tx_done";
            default: return "sr_load";
        endcase
    endfunction

    // Expected {tx, tx_ready, busy, sr_shift, tx_done} at offset 1..L into a frame.
    function automatic logic [4:0] frame_exp(input int off, input logic [7:0] b, input int sb);
        int   slot;
        logic txv;
        logic sh;
        slot = (off - 1) / C;
        if (slot == 0)      txv = 1'b0;
        else if (slot <= 8) txv = b[slot-1];
        else                txv = 1'b1;
        sh = ((off % C) == 0) && (off / C >= 1) && (off / C <= 8);
        return {txv, 1'b0, 1'b1, sh, (off == (9 + sb) * C)};
    endfunction

    task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s inst%0d cyc=%0d got=%h expected=%h", nm, i, cyc, act, exp);
        end
    endtask

    // single compare process: model + per-cycle check + literal pins
    logic [5:0] e;
    logic [5:0] a_arr [2];
    int sb, len, off;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            sb  = (i == 0) ? 1 : 2;
            len = (9 + sb) * C;
            if (!reset) begin
                hv[i] = 1'b0;
                e = 6'b110000;
                chk("sr_data_rst", i, sr_data_a[i], 8'h00);
            end else begin
                off = cyc - t_acc[i];
                if (hv[i] && off >= 1 && off <= len) begin
                    e = {frame_exp(off, fb[i], sb), 1'b0};
                end else begin
                    e = {5'b11000, tx_valid_a[i]};
                    if (tx_valid_a[i]) begin
                        t_acc[i] = cyc;
                        fb[i]    = tx_data_a[i];
                        hv[i]    = 1'b1;
                        chk("sr_data", i, sr_data_a[i], tx_data_a[i]);
                    end
                end
            end
            a_arr[i] = {tx_a[i], tx_ready_a[i], busy_a[i], shift_a[i], tx_done_a[i], load_a[i]};
            for (int s = 0; s < 6; s++)
                chk(sig_name(s), i, {7'b0, a_arr[i][5-s]}, {7'b0, e[5-s]});
        end
        for (int p = 0; p < npins; p++)
            if (pin_cyc[p] == cyc)
                chk({"pin_", sig_name(pin_sig[p])}, pin_inst[p],
                    {7'b0, a_arr[pin_inst[p]][5-pin_sig[p]]}, {7'b0, pin_val[p]});
    end

    task automatic pin(input int c, input int i, input int s, input logic v);
        pin_cyc[npins]  = c;
        pin_inst[npins] = i;
        pin_sig[npins]  = s;
        pin_val[npins]  = v;
        npins++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a byte and hold valid until accepted; returns the accept cycle.
    task automatic send(input int i, input logic [7:0] b, input bit hold,
                        input logic [7:0] after, output int t);
        int n;
        n = 0;
        tx_valid_a[i] = 1'b1;
        tx_data_a[i]  = b;
        @(negedge clk);
        while (!tx_ready_a[i]) begin
            n++;
            if (n > 200) begin
                $display("FAIL send_timeout inst%0d got=no_accept expected=accept", i);
                $fatal(1);
            end
            @(negedge clk);
        end
        t = cyc;
        @(posedge clk);
        #1;
        tx_data_a[i] = after;
        if (!hold) tx_valid_a[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int t, t2;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(2);

        // single 0xA5 frame with a busy-time request for 0x3C
        send(0, 8'hA5, 1'b0, 8'h00, t);
        pin(t+1, 0, 0, 1'b0);  pin(t+4, 0, 0, 1'b0);
        pin(t+5, 0, 0, 1'b1);  pin(t+9, 0, 0, 1'b0);
        pin(t+13, 0, 0, 1'b1); pin(t+33, 0, 0, 1'b1);
        pin(t+4, 0, 3, 1'b1);  pin(t+32, 0, 3, 1'b1);  pin(t+36, 0, 3, 1'b0);
        pin(t+39, 0, 4, 1'b0); pin(t+40, 0, 4, 1'b1);
        pin(t+40, 0, 1, 1'b0); pin(t+41, 0, 1, 1'b1);
        pin(t+40, 0, 2, 1'b1); pin(t+41, 0, 2, 1'b0);
        pin(t+10, 0, 5, 1'b0);
        wait_until(t + 10);
        tx_valid_a[0] = 1'b1;
        tx_data_a[0]  = 8'h3C;
        wait_cyc(1);
        tx_valid_a[0] = 1'b0;
        wait_until(t + 45);

        // data changes right after accept
        send(0, 8'h0F, 1'b0, 8'hFF, t);
        pin(t+21, 0, 0, 1'b0); pin(t+17, 0, 0, 1'b1);
        wait_until(t + 45);

        // back-to-back with valid held high
        send(0, 8'h55, 1'b1, 8'h55, t);
        pin(t+40, 0, 0, 1'b1); pin(t+41, 0, 0, 1'b1); pin(t+42, 0, 0, 1'b0);
        pin(t+41, 0, 5, 1'b1); pin(t+40, 0, 5, 1'b0);
        send(0, 8'hFF, 1'b0, 8'h00, t2);
        wait_until(t2 + 45);

        // two stop bits, byte 0x80
        send(1, 8'h80, 1'b0, 8'h00, t);
        pin(t+5, 1, 0, 1'b0);  pin(t+33, 1, 0, 1'b1);
        pin(t+37, 1, 0, 1'b1); pin(t+44, 1, 0, 1'b1);
        pin(t+43, 1, 4, 1'b0); pin(t+44, 1, 4, 1'b1);
        pin(t+44, 1, 1, 1'b0); pin(t+45, 1, 1, 1'b1);
        wait_until(t + 50);

        // randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 9) == 0) tx_valid_a[i] = ~tx_valid_a[i];
                tx_data_a[i] = 8'($urandom);
            end
            wait_cyc(1);
        end
        tx_valid_a[0] = 1'b0;
        tx_valid_a[1] = 1'b0;
        wait_cyc(120);

        // reset asserted mid-DATA, then 0x00 frames
        send(0, 8'hC3, 1'b0, 8'h00, t);
        wait_until(t + 15);
        reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(1);
        send(0, 8'h00, 1'b1, 8'h00, t);
        pin(t+5, 0, 0, 1'b0); pin(t+37, 0, 0, 1'b1); pin(t+40, 0, 4, 1'b1);
        send(0, 8'h00, 1'b0, 8'h00, t2);
        wait_until(t2 + 45);

        wait_cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
